// File: rtl/syn_delay_prog.sv
// syn_delay_prog: programmable multi-lane sample delay line with flush, runtime delay load and passthrough at D=0.
module syn_delay_prog #(
    parameter int BITWIDTH = 16,
    parameter int CHANNELS = 1,
    parameter int MAXDELAY = 100,
    parameter int DEFDELAY = 100,
    localparam int DW = $clog2(MAXDELAY + 1)
) (
    input  logic                         clk,
    input  logic                         grst,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         load,
    input  logic [DW-1:0]                dly,
    input  logic [BITWIDTH*CHANNELS-1:0] inp,
    output logic [BITWIDTH*CHANNELS-1:0] outp,
    output logic                         outv,
    output logic                         err,
    output logic [DW-1:0]                cur_dly
);
    localparam int W  = BITWIDTH * CHANNELS;
    localparam int AW = MAXDELAY > 1 ? $clog2(MAXDELAY) : 1;

    if (DEFDELAY > MAXDELAY) begin : g_bad_default
        $error("syn_delay_prog: DEFDELAY must not exceed MAXDELAY");
    end
    if (MAXDELAY < 1 || MAXDELAY > 65535) begin : g_bad_max
        $error("syn_delay_prog: MAXDELAY must be within 1..65535");
    end

    logic [W-1:0]  mem [MAXDELAY];
    logic [AW-1:0] wp, rp;
    logic [DW-1:0] d, n;
    logic [DW:0]   n1;
    logic [W-1:0]  q;
    logic          v, hit, over;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(MAXDELAY - 1)) ? '0 : p + 1'b1;
    endfunction

    // hit: this enabled edge completes D samples since the last flush
    always_comb begin
        n1      = {1'b0, n} + 1'b1;
        hit     = n1 >= {1'b0, d};
        over    = dly > DW'(MAXDELAY);
        outp    = (d == '0) ? inp : q;
        outv    = (d == '0) | v;
        cur_dly = d;
    end

    // rp trails wp by D-1 entries once filled; it restarts at wp on every flush
    always_ff @(posedge clk) begin
        if (grst || rst) begin
            if (grst) d <= DW'(DEFDELAY);
            n   <= '0;
            err <= 1'b0;
            q   <= '0;
            v   <= 1'b0;
            wp  <= '0;
            rp  <= '0;
        end else if (load) begin
            d   <= over ? DW'(MAXDELAY) : dly;
            err <= err | over;
            n   <= '0;
            q   <= '0;
            v   <= 1'b0;
            rp  <= wp;
        end else if (en) begin
            wp <= nxt(wp);
            n  <= hit ? d : n1[DW-1:0];
            v  <= hit;
            q  <= hit ? ((d == DW'(1)) ? inp : mem[rp]) : '0;
            if (hit) rp <= nxt(rp);
        end
    end

    always_ff @(posedge clk) begin
        if (en && !grst && !rst && !load) mem[wp] <= inp;
    end
endmodule

// File: tb/tb_syn_delay_prog.sv
// tb_syn_delay_prog: randomized and directed checks of syn_delay_prog against a sample-history queue model.
module tb_syn_delay_prog;
    localparam int BW  = 8;
    localparam int CH  = 4;
    localparam int MAX = 100;
    localparam int DEF = 100;
    localparam int DW  = $clog2(MAX + 1);
    localparam int W   = BW * CH;

    logic          clk = 0, grst = 0, rst = 0, en = 0, load = 0;
    logic [DW-1:0] dly = '0;
    logic [W-1:0]  inp = '0;
    logic [W-1:0]  outp;
    logic          outv, err;
    logic [DW-1:0] cur_dly;

    int checks = 0, failures = 0;
    int md = DEF;
    bit merr = 0;
    logic [W-1:0] hist[$];

    syn_delay_prog #(.BITWIDTH(BW), .CHANNELS(CH), .MAXDELAY(MAX), .DEFDELAY(DEF)) dut (
        .clk(clk), .grst(grst), .rst(rst), .en(en), .load(load), .dly(dly),
        .inp(inp), .outp(outp), .outv(outv), .err(err), .cur_dly(cur_dly)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pat(input int k);
        return {8'(48 + k), 8'(32 + k), 8'(16 + k), 8'(k)};
    endfunction

    // one clock edge: drive, update the model from the stated rules, compare
    task automatic cyc(input bit g, input bit r, input bit l, input int dl, input bit e, input logic [W-1:0] x);
        logic [W-1:0] eo;
        bit ev;
        grst = g; rst = r; load = l; dly = DW'(dl); en = e; inp = x;
        @(posedge clk);
        if (g) begin
            md = DEF; merr = 0; hist.delete();
        end else if (r) begin
            merr = 0; hist.delete();
        end else if (l) begin
            md = (dl > MAX) ? MAX : dl;
            if (dl > MAX) merr = 1;
            hist.delete();
        end else if (e) begin
            hist.push_back(x);
            if (hist.size() > MAX + 1) void'(hist.pop_front());
        end
        if (md == 0) begin
            eo = x; ev = 1;
        end else if (hist.size() >= md) begin
            eo = hist[hist.size() - md]; ev = 1;
        end else begin
            eo = '0; ev = 0;
        end
        #1;
        chk("outp", outp, eo);
        chk("outv", 32'(outv), 32'(ev));
        chk("err", 32'(err), 32'(merr));
        chk("cur_dly", 32'(cur_dly), 32'(md));
    endtask

    initial begin
        logic [W-1:0] seq [4];
        seq[0] = '0; seq[1] = '0; seq[2] = 32'd10; seq[3] = 32'd11;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, '0);
        chk("rst_outv", 32'(outv), 0);
        chk("rst_cur", 32'(cur_dly), DEF);
        chk("rst_err", 32'(err), 0);
        for (int k = 1; k <= 3 * MAX; k++) begin
            cyc(0, 0, 0, 0, 1, pat(k));
            if (k == 99) chk("dflt_fill", 32'(outv), 0);
            if (k == 100) chk("dflt_first", outp, pat(1));
            if (k == 3 * MAX) chk("wrap_lanes", outp, pat(201));
        end
        cyc(0, 0, 1, 3, 1, pat(250));
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1, 32'(10 + k));
            chk("d3_seq", outp, seq[k]);
        end
        cyc(0, 0, 0, 0, 1, 32'd14);
        chk("d3_en1", outp, 32'd12);
        cyc(0, 0, 0, 0, 0, 32'd99);
        chk("d3_hold", outp, 32'd12);
        cyc(0, 0, 0, 0, 1, 32'd15);
        chk("d3_en1b", outp, 32'd13);
        cyc(0, 0, 1, 5, 1, 32'd77);
        chk("ld5_drop", 32'(outv), 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1, 32'(20 + k));
        chk("ld5_first", outp, 32'd20);
        cyc(0, 0, 1, MAX + 7, 1, '0);
        chk("ovr_cur", 32'(cur_dly), MAX);
        chk("ovr_err", 32'(err), 1);
        cyc(0, 0, 1, 4, 0, '0);
        chk("ovr_sticky", 32'(err), 1);
        cyc(0, 1, 0, 0, 0, '0);
        chk("rst_clr_err", 32'(err), 0);
        chk("rst_keep_d", 32'(cur_dly), 4);
        cyc(0, 0, 1, 0, 0, '0);
        inp = 32'h12345678; en = 0; #1;
        chk("pass_en0", outp, 32'h12345678);
        inp = 32'hcafef00d; en = 1; #1;
        chk("pass_en1", outp, 32'hcafef00d);
        chk("pass_v", 32'(outv), 1);
        @(negedge clk);
        cyc(0, 0, 1, 1, 0, '0);
        chk("d1_v0", 32'(outv), 0);
        cyc(0, 0, 0, 0, 1, 32'd7);
        chk("d1_out", outp, 32'd7);
        chk("d1_v1", 32'(outv), 1);
        for (int i = 0; i < 3000; i++) begin
            int p;
            int dl;
            p  = $urandom_range(0, 999);
            dl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 8);
            cyc(p < 8, p >= 8 && p < 25, ($urandom_range(0, 99) < 4) || p < 12, dl,
                $urandom_range(0, 9) < 7, $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/syn_delay_prog.md
SYN_DELAY_PROG -- requirements
Module: syn_delay_prog

Interface
REQ-001 Parameter BITWIDTH, default 16: width of one channel sample.
REQ-002 Parameter CHANNELS, default 1: number of parallel lanes sharing one delay setting.
REQ-003 Parameter MAXDELAY, default 100: largest supported delay in enabled cycles, valid range 1..65535.
REQ-004 Parameter DEFDELAY, default 100: delay applied after grst; elaboration SHALL fail if DEFDELAY > MAXDELAY.
REQ-005 Localparam DW = ceil(log2(MAXDELAY+1)): width of the delay fields.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 grst  input  1  reset grst, synchronous, active-high; global reset.
REQ-008 rst  input  1  synchronous active-high local flush; keeps the programmed delay.
REQ-009 en  input  1  clock enable; sample/advance only on edges with en=1.
REQ-010 load  input  1  synchronous strobe; captures dly as the new delay.
REQ-011 dly  input  DW  requested delay, sampled only on load edges.
REQ-012 inp  input  BITWIDTH*CHANNELS  input samples; lane c occupies bits [c*BITWIDTH +: BITWIDTH].
REQ-013 outp  output  BITWIDTH*CHANNELS  delayed samples, same lane packing.
REQ-014 outv  output  1  high when outp carries genuinely delayed data, not fill zeros.
REQ-015 err  output  1  sticky flag: out-of-range dly was loaded.
REQ-016 cur_dly  output  DW  currently active delay D.

Function
REQ-017 Priority on each rising edge SHALL be grst > rst > load > en.
REQ-018 Let x_k be inp sampled at the k-th en=1 edge since the last grst, rst or load edge, and n the count of such edges; for D>=1, after the n-th edge outp SHALL equal x_(n-D+1) if n>=D, else all zeros.
REQ-019 For D>=1, outv SHALL be 1 iff n>=D; n SHALL saturate at D, with no wrap.
REQ-020 With en=0 (and no grst/rst/load), outp, outv, n and storage SHALL hold.
REQ-021 D=1 SHALL behave as a single enabled register: latency one enabled edge.
REQ-022 D=0 SHALL give combinational passthrough: outp=inp, outv=1 regardless of en.
REQ-023 On a load edge: D <= min(dly, MAXDELAY); n <= 0; outp <= 0 (for D>=1 after load); outv <= 0 (1 if new D=0); inp on that edge SHALL NOT be sampled even if en=1.
REQ-024 If dly > MAXDELAY on a load edge, err SHALL be set and remain set until grst or rst.
REQ-025 All lanes SHALL share D, n and outv; lanes SHALL never mix data.
REQ-026 Storage SHALL be a circular buffer of MAXDELAY entries of BITWIDTH*CHANNELS bits, with a write pointer wrapping MAXDELAY-1 -> 0.
REQ-027 Storage contents SHALL NOT require reset; stale data SHALL be masked to zeros by the n<D gating (RAM-inferable).
REQ-028 Changing D via load mid-stream SHALL discard all prior history; no pre-load sample SHALL appear on outp.
REQ-029 A load with the same D as current SHALL still flush (n <= 0).
REQ-030 The correct sample SHALL appear at D=MAXDELAY with the pointer wrapped any number of times.

Reset
REQ-031 grst=1 on an edge: D <= DEFDELAY, n <= 0, err <= 0, outp <= 0 (for DEFDELAY>=1), outv <= 0, write pointer <= 0.
REQ-032 rst=1 on an edge: same as grst except D SHALL be retained.
REQ-033 grst or rst asserted together with load SHALL ignore the load.
REQ-034 Reset mid-operation SHALL require D fresh enabled samples before outv returns to 1.

Verification
REQ-035 grst, en=1 continuous, inp=1,2,3,... with DEFDELAY=100 -> outp=0 and outv=0 for 99 edges; on the 100th edge outp=1, outv=1; then tracks inp minus 99 each edge.
REQ-036 load dly=3, then inp=10,11,12,13 with en=1 -> outp 0,0,10,11 and outv 0,0,1,1; with en toggling 1,0,1 the output advances only on en=1 edges.
REQ-037 Mid-stream load dly=5 while D=3 and outv=1 -> outv drops the next edge; first nonzero outp is the first post-load sample, after the 5th enabled edge.
REQ-038 load dly=MAXDELAY+7 -> cur_dly=MAXDELAY, err=1; err persists through a later valid load and clears on rst.
REQ-039 load dly=0 -> outp==inp combinationally with en=0 and en=1, outv=1; then load dly=1 -> one-edge latency, outv=1 after the first enabled edge.
REQ-040 CHANNELS=4, BITWIDTH=8, lane c driven with c*16+k at the k-th sample, D=MAXDELAY, run 3*MAXDELAY edges -> every lane correct across pointer wrap, no lane crosstalk.
